// File: rtl/dac_serial_mux.sv
// dac_serial_mux - multi-channel serial DAC writer.
//
// Latches per-channel DAC codes on rising update strobes, grants channels
// round-robin and shifts each code MSB-first onto a shared sclk/din pair.
// Each DAC has its own active-low enable.
//
// Parameters: NCH (channels), DATA_W (bits per word), HALF (clocks per
// serial-clock half period; sclk = clock / (2*HALF)).
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   data[NCH*DATA_W]    channel i code at [i*DATA_W +: DATA_W]
//   update[NCH]         per-channel write request (rising edge only)
//   pending[NCH]        latched request not yet sent
//   busy                frame in progress (SETUP..HOLD)
//   done                one-cycle pulse on return to IDLE
//   dac_en_n[NCH]       active-low per-DAC enable (at most one low)
//   dac_sclk, dac_din   shared serial clock (idles low) and data
//
// Optional feature, macro DAC_READBACK_EN:
//   dac_sdo             serial readback, sampled on rising sclk
//   readback[DATA_W]    captured word, updated on the done cycle
//   readback_valid      pulses with done
module dac_serial_mux #(
  parameter int NCH    = 4,
  parameter int DATA_W = 14,
  parameter int HALF   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH*DATA_W-1:0] data,
  input  logic [NCH-1:0]        update,
  output logic [NCH-1:0]        pending,
  output logic                  busy,
  output logic                  done,
  output logic [NCH-1:0]        dac_en_n,
  output logic                  dac_sclk,
`ifdef DAC_READBACK_EN
  output logic                  dac_din,
  input  logic                  dac_sdo,
  output logic [DATA_W-1:0]     readback,
  output logic                  readback_valid
`else
  output logic                  dac_din
`endif
);

  localparam int CNT_W = $clog2(HALF);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                        state_q, state_d;
  logic [NCH-1:0]                upd_s_q, upd_p_q;
  logic [NCH-1:0]                pending_q, pending_d;
  logic [NCH-1:0][DATA_W-1:0]    shadow_q, shadow_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BIT_W-1:0]              bits_q, bits_d;
  logic [DATA_W-1:0]             sh_q, sh_d;
  logic [IDX_W-1:0]              rr_q, rr_d;
  logic [NCH-1:0]                en_n_q, en_n_d;
  logic                          sclk_q, sclk_d;
  logic                          din_q, din_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [NCH-1:0]                rise;
  logic                          tick;
  logic [IDX_W-1:0]              pick;

  // First requesting channel at or after 'start', wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NCH-1:0] req,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] r;
    int idx;
    r = start;
    // Walk offsets high to low so the smallest offset is the final winner.
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) r = IDX_W'(idx);
    end
    return r;
  endfunction

  assign rise = upd_s_q & ~upd_p_q;
  assign tick = (state_q != IDLE) && (cnt_q == CNT_W'(HALF - 1));
  assign pick = rr_pick(pending_q, rr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == IDLE) ? '0 : (tick ? '0 : cnt_q + CNT_W'(1));
    bits_d    = bits_q;
    sh_d      = sh_q;
    rr_d      = rr_q;
    en_n_d    = en_n_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d          = SETUP;
          sh_d             = shadow_q[pick];
          din_d            = shadow_q[pick][DATA_W-1];
          en_n_d           = ~(NCH'(1) << pick);
          busy_d           = 1'b1;
          bits_d           = '0;
          pending_d[pick]  = 1'b0;
          rr_d             = (int'(pick) == NCH - 1) ? '0 : pick + IDX_W'(1);
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling sclk: advance to the next bit, or finish after the
            // last one leaving din on the LSB.
            if (bits_q == BIT_W'(DATA_W - 1)) begin
              state_d = HOLD;
            end else begin
              sh_d   = sh_q << 1;
              din_d  = sh_q[DATA_W-2];
              bits_d = bits_q + BIT_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          en_n_d  = '1;
          din_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new rise always wins, including on the edge its channel is granted.
    for (int i = 0; i < NCH; i++) begin
      if (rise[i]) begin
        pending_d[i] = 1'b1;
        shadow_d[i]  = data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Edge detector follows the live input so a held strobe is ignored.
      upd_s_q   <= update;
      upd_p_q   <= update;
      state_q   <= IDLE;
      pending_q <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      bits_q    <= '0;
      sh_q      <= '0;
      rr_q      <= '0;
      en_n_q    <= '1;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      upd_s_q   <= update;
      upd_p_q   <= upd_s_q;
      state_q   <= state_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      sh_q      <= sh_d;
      rr_q      <= rr_d;
      en_n_q    <= en_n_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pending  = pending_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dac_en_n = en_n_q;
  assign dac_sclk = sclk_q;
  assign dac_din  = din_q;

`ifdef DAC_READBACK_EN
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              rbv_q, rbv_d;

  always_comb begin
    cap_d = cap_q;
    rb_d  = rb_q;
    rbv_d = 1'b0;
    if (state_q == IDLE && |pending_q) cap_d = '0;
    // sclk is about to rise: this is the DAC's sampling point.
    if (state_q == SHIFT && tick && !sclk_q) cap_d = {cap_q[DATA_W-2:0], dac_sdo};
    if (state_q == HOLD && tick) begin
      rb_d  = cap_q;
      rbv_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_q <= '0;
      rb_q  <= '0;
      rbv_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      rb_q  <= rb_d;
      rbv_q <= rbv_d;
    end
  end

  assign readback       = rb_q;
  assign readback_valid = rbv_q;
`endif

endmodule

// File: tb/tb_dac_serial_mux.sv
// Directed testbench for dac_serial_mux (NCH=4, DATA_W=14, HALF=8).
// A frame monitor records channel, enable-low length, the bits seen on
// rising sclk and the done flag; stimulus compares them to fixed values.
module tb_dac_serial_mux;

  localparam int NCH    = 4;
  localparam int DATA_W = 14;
  localparam int HALF   = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NCH*DATA_W-1:0] data;
  logic [NCH-1:0]        update;
  logic [NCH-1:0]        pending;
  logic                  busy, done;
  logic [NCH-1:0]        dac_en_n;
  logic                  dac_sclk, dac_din;
`ifdef DAC_READBACK_EN
  logic                  dac_sdo = 1'b0;
  logic [DATA_W-1:0]     readback;
  logic                  readback_valid;
`endif

  dac_serial_mux #(.NCH(NCH), .DATA_W(DATA_W), .HALF(HALF)) dut (
    .clock(clock), .reset(reset), .data(data), .update(update),
    .pending(pending), .busy(busy), .done(done), .dac_en_n(dac_en_n),
    .dac_sclk(dac_sclk),
`ifdef DAC_READBACK_EN
    .dac_din(dac_din), .dac_sdo(dac_sdo), .readback(readback),
    .readback_valid(readback_valid)
`else
    .dac_din(dac_din)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame monitor
  int          fr_ch[$], fr_len[$], fr_bits[$], fr_gap[$];
  logic [31:0] fr_word[$];
  logic        fr_done[$];
  int          done_cnt = 0, multi_low = 0, rbv_cnt = 0, rbv_with_done = 0;
  int          cur_ch = 0, cur_len = 0, cur_bits = 0, gap_cnt = 0, cur_gap = 0;
  logic [31:0] cur_word = '0;
  logic        prev_idle = 1'b1, prev_sclk = 1'b0;

  always begin
    @(posedge clock);
    #2;
    if (dac_en_n !== '1) begin
      if (prev_idle) begin
        cur_len = 0; cur_bits = 0; cur_word = '0; cur_gap = gap_cnt;
        for (int i = 0; i < NCH; i++) if (dac_en_n[i] === 1'b0) cur_ch = i;
      end
      if ($countones(~dac_en_n) != 1) multi_low++;
      cur_len++;
      if (dac_sclk && !prev_sclk) begin
        cur_word = {cur_word[30:0], dac_din};
        cur_bits++;
      end
    end else begin
      if (!prev_idle) begin
        fr_ch.push_back(cur_ch); fr_len.push_back(cur_len);
        fr_bits.push_back(cur_bits); fr_word.push_back(cur_word);
        fr_done.push_back(done); fr_gap.push_back(cur_gap);
        gap_cnt = 0;
      end
      gap_cnt++;
    end
    prev_idle = (dac_en_n === '1);
    prev_sclk = dac_sclk;
    if (done === 1'b1) done_cnt++;
`ifdef DAC_READBACK_EN
    if (readback_valid === 1'b1) begin
      rbv_cnt++;
      if (done === 1'b1) rbv_with_done++;
    end
`endif
  end

`ifdef DAC_READBACK_EN
  logic [DATA_W-1:0] rb_word = 14'h1234;
  int   rcnt = 0;
  logic sd_prev = 1'b0;
  // Present the next readback bit ahead of each rising sclk.
  always begin
    @(posedge clock);
    #3;
    if (dac_en_n === '1) rcnt = 0;
    else if (dac_sclk && !sd_prev) rcnt++;
    sd_prev = dac_sclk;
    dac_sdo = (rcnt < DATA_W) ? rb_word[DATA_W-1-rcnt] : 1'b0;
  end
`endif

  task automatic clear_frames();
    fr_ch.delete(); fr_len.delete(); fr_bits.delete();
    fr_word.delete(); fr_done.delete(); fr_gap.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (fr_ch.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check_val("frames_seen", fr_ch.size(), n);
  endtask

  task automatic check_frame(input string tag, input int idx, input int ch, input logic [31:0] word);
    if (idx < fr_ch.size()) begin
      check_val({tag, "_ch"}, fr_ch[idx], ch);
      check_val({tag, "_len"}, fr_len[idx], 240);
      check_val({tag, "_bits"}, fr_bits[idx], 14);
      check_val({tag, "_word"}, fr_word[idx], word);
      check_val({tag, "_done"}, fr_done[idx], 1);
    end else begin
      check_val({tag, "_present"}, fr_ch.size(), idx + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    reset = 1'b1; update = '0; data = '0;
    step(1);
    check_val("rst_en_n", dac_en_n, 4'hF);
    check_val("rst_sclk", dac_sclk, 0);
    check_val("rst_din", dac_din, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pending", pending, 0);
    step(2);
    reset = 1'b0;
    step(2);

    // Single write: channel 0, 0x2A5A
    clear_frames();
    d0 = done_cnt;
    data[0*DATA_W +: DATA_W] = 14'h2A5A;
    update[0] = 1'b1;
    step(1);
    check_val("lat_pend_e0", pending, 4'h0);
    step(1);
    check_val("lat_pend_e1", pending, 4'h1);
    check_val("lat_en_e1", dac_en_n, 4'hF);
    step(1);
    check_val("lat_en_e2", dac_en_n, 4'hE);
    check_val("setup_busy", busy, 1);
    check_val("setup_din_msb", dac_din, 1);
    check_val("setup_sclk", dac_sclk, 0);
    check_val("setup_pend_clr", pending, 4'h0);
    update[0] = 1'b0;
    wait_frames(1, 600);
    check_frame("single", 0, 0, 32'h2A5A);
    check_val("single_done_cnt", done_cnt - d0, 1);
    check_val("idle_din", dac_din, 0);
    check_val("idle_busy", busy, 0);

    // Simultaneous requests on channels 1 and 3
    step(3);
    clear_frames();
    data[1*DATA_W +: DATA_W] = 14'h1111;
    data[3*DATA_W +: DATA_W] = 14'h0ABC;
    update = 4'b1010;
    step(2);
    check_val("sim_pend_a", pending, 4'hA);
    step(1);
    check_val("sim_pend_b", pending, 4'h8);
    check_val("sim_en_first", dac_en_n, 4'hD);
    update = '0;
    wait_frames(2, 1200);
    check_frame("sim_f0", 0, 1, 32'h1111);
    check_frame("sim_f1", 1, 3, 32'h0ABC);
    if (fr_gap.size() > 1) check_val("sim_gap", fr_gap[1], 1);
    check_val("sim_pend_end", pending, 4'h0);

    // Latest code wins on channel 2 while channel 0 is busy
    step(3);
    clear_frames();
    data[0*DATA_W +: DATA_W] = 14'h0F0F;
    update[0] = 1'b1;
    step(3);
    check_val("lw_en_ch0", dac_en_n, 4'hE);
    update[0] = 1'b0;
    data[2*DATA_W +: DATA_W] = 14'h0001;
    update[2] = 1'b1;
    step(3);
    update[2] = 1'b0;
    step(3);
    data[2*DATA_W +: DATA_W] = 14'h3FFF;
    update[2] = 1'b1;
    step(3);
    update[2] = 1'b0;
    check_val("lw_pend_mid", pending, 4'h4);
    wait_frames(2, 1200);
    step(300);
    check_val("lw_frame_count", fr_ch.size(), 2);
    check_frame("lw_f0", 0, 0, 32'h0F0F);
    check_frame("lw_f1", 1, 2, 32'h3FFF);

    // Round robin: last served was 2, so 3 goes ahead of 1
    clear_frames();
    data[1*DATA_W +: DATA_W] = 14'h2222;
    data[3*DATA_W +: DATA_W] = 14'h1333;
    update = 4'b1010;
    step(3);
    update = '0;
    wait_frames(2, 1200);
    check_frame("rr_f0", 0, 3, 32'h1333);
    check_frame("rr_f1", 1, 1, 32'h2222);

    // Held strobe gives a single frame
    step(3);
    clear_frames();
    data[1*DATA_W +: DATA_W] = 14'h1555;
    update[1] = 1'b1;
    step(1000);
    check_val("held_frames", fr_ch.size(), 1);
    if (fr_ch.size() > 0) check_val("held_word", fr_word[0], 32'h1555);
    update[1] = 1'b0;
    step(3);

    // Reset at clock 100 of a frame
    clear_frames();
    d0 = done_cnt;
    data[0*DATA_W +: DATA_W] = 14'h2000;
    update[0] = 1'b1;
    step(3);
    check_val("rmf_en", dac_en_n, 4'hE);
    update[0] = 1'b0;
    update[2] = 1'b1;
    step(97);
    check_val("rmf_pend_pre", pending, 4'h4);
    reset = 1'b1;
    step(1);
    check_val("rmf_en_n", dac_en_n, 4'hF);
    check_val("rmf_sclk", dac_sclk, 0);
    check_val("rmf_din", dac_din, 0);
    check_val("rmf_pending", pending, 0);
    check_val("rmf_busy", busy, 0);
    check_val("rmf_done", done, 0);
    step(2);
    reset = 1'b0;
    step(300);
    check_val("rmf_frames", fr_ch.size(), 1);
    if (fr_done.size() > 0) check_val("rmf_abort_done", fr_done[0], 0);
    check_val("rmf_done_cnt", done_cnt - d0, 0);
    check_val("rmf_pend_post", pending, 0);
    update[2] = 1'b0;
    step(3);

`ifdef DAC_READBACK_EN
    clear_frames();
    rbv_cnt = 0; rbv_with_done = 0;
    data[1*DATA_W +: DATA_W] = 14'h0000;
    update[1] = 1'b1;
    step(3);
    update[1] = 1'b0;
    wait_frames(1, 600);
    check_val("rb_value", readback, 32'h1234);
    check_val("rb_valid_cnt", rbv_cnt, 1);
    check_val("rb_valid_done", rbv_with_done, 1);
`endif

    check_val("one_enable_low", multi_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
